// File: rtl/product_register_ctrl_if.sv
// Bundle between the product/multiplicand register controller, its operand source
// and the combinational adder stage of the shift-add multiplier.
interface product_register_ctrl_if #(
   parameter int DATA_W = 32
);
   logic                  Run;
   logic [DATA_W-1:0]     Multiplicand_in;
   logic [DATA_W-1:0]     Multiplier_in;
   logic                  ALU_carry;
   logic [DATA_W-1:0]     ALU_result;
   logic [DATA_W-1:0]     Product_hi;
   logic [DATA_W-1:0]     Multiplicand;
   logic                  Addu_ctrl;
   logic [2*DATA_W-1:0]   Product;
   logic                  Busy;
   logic                  Ready;

   modport master (
      output Run, Multiplicand_in, Multiplier_in, ALU_carry, ALU_result,
      input  Product_hi, Multiplicand, Addu_ctrl, Product, Busy, Ready
   );

   modport slave (
      input  Run, Multiplicand_in, Multiplier_in, ALU_carry, ALU_result,
      output Product_hi, Multiplicand, Addu_ctrl, Product, Busy, Ready
   );
endinterface

// File: rtl/product_register_ctrl.sv
// Sequential half of the shift-add unsigned multiplier: product/multiplier and
// multiplicand registers plus the DATA_W-iteration control FSM.
module product_register_ctrl #(
   parameter int DATA_W = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   product_register_ctrl_if.slave  bus
);
   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]            state_q,   state_d;
   logic [2*DATA_W-1:0]   product_q, product_d;
   logic [DATA_W-1:0]     mcand_q,   mcand_d;
   logic [CNT_W-1:0]      count_q,   count_d;

   always_comb begin
      state_d   = state_q;
      product_d = product_q;
      mcand_d   = mcand_q;
      count_d   = count_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.Run) begin
               product_d = {{DATA_W{1'b0}}, bus.Multiplier_in};
               mcand_d   = bus.Multiplicand_in;
               count_d   = '0;
               state_d   = ST_CALC;
            end
         end
         ST_CALC: begin
            // Adder returns carry=0, result=Src_1 when not enabled, so the shift is uniform.
            product_d = {bus.ALU_carry, bus.ALU_result, product_q[DATA_W-1:1]};
            count_d   = count_q + CNT_W'(1);
            if (count_q == CNT_LAST) begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         product_q <= '0;
         mcand_q   <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         product_q <= product_d;
         mcand_q   <= mcand_d;
         count_q   <= count_d;
      end
   end

   assign bus.Product      = product_q;
   assign bus.Product_hi   = product_q[2*DATA_W-1:DATA_W];
   assign bus.Multiplicand = mcand_q;
   assign bus.Addu_ctrl    = (state_q == ST_CALC) && product_q[0];
   assign bus.Busy         = (state_q == ST_CALC);
   assign bus.Ready        = (state_q == ST_DONE);
endmodule

// File: tb/tb_product_register_ctrl.sv
// Directed bench for product_register_ctrl with a behavioural adder closing the loop.
module tb_product_register_ctrl;
   localparam int DATA_W = 32;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   product_register_ctrl_if #(.DATA_W(DATA_W)) bus();

   product_register_ctrl #(.DATA_W(DATA_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Behavioural adder: Src_1 = Product_hi, Src_2 = Multiplicand gated by Addu_ctrl.
   logic [DATA_W:0] adder_sum;
   assign adder_sum      = {1'b0, bus.Product_hi} + {1'b0, (bus.Addu_ctrl ? bus.Multiplicand : {DATA_W{1'b0}})};
   assign bus.ALU_carry  = adder_sum[DATA_W];
   assign bus.ALU_result = adder_sum[DATA_W-1:0];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present operands with Run=1 across one edge; optionally leave Run asserted.
   task automatic start_op(input logic [31:0] mcand, input logic [31:0] mplier, input bit keep_run);
      bus.Run             = 1'b1;
      bus.Multiplicand_in = mcand;
      bus.Multiplier_in   = mplier;
      step();
      if (!keep_run) bus.Run = 1'b0;
   endtask

   task automatic wait_ready(output int cyc, output int busy_cyc, output bit addu_seen);
      cyc       = 0;
      busy_cyc  = 0;
      addu_seen = 1'b0;
      while (!bus.Ready && cyc < 100) begin
         if (bus.Busy)      busy_cyc++;
         if (bus.Addu_ctrl) addu_seen = 1'b1;
         step();
         cyc++;
      end
   endtask

   int cyc, busy_cyc;
   bit addu_seen;

   initial begin
      checks              = 0;
      failures            = 0;
      rst_n               = 1'b0;
      bus.Run             = 1'b0;
      bus.Multiplicand_in = '0;
      bus.Multiplier_in   = '0;
      step();
      step();
      check("rst_product", bus.Product, 64'd0);
      check("rst_mcand", {32'd0, bus.Multiplicand}, 64'd0);
      check("rst_busy", {63'd0, bus.Busy}, 64'd0);
      check("rst_ready", {63'd0, bus.Ready}, 64'd0);
      check("rst_addu", {63'd0, bus.Addu_ctrl}, 64'd0);
      rst_n = 1'b1;
      step();
      check("idle_no_run_busy", {63'd0, bus.Busy}, 64'd0);

      // 3 * 5
      start_op(32'd3, 32'd5, 1'b0);
      check("load_product", bus.Product, 64'd5);
      check("load_mcand", {32'd0, bus.Multiplicand}, 64'd3);
      wait_ready(cyc, busy_cyc, addu_seen);
      check("m3x5_ready", {63'd0, bus.Ready}, 64'd1);
      check("m3x5_cycles", 64'(cyc), 64'd32);
      check("m3x5_busy_cycles", 64'(busy_cyc), 64'd32);
      check("m3x5_product", bus.Product, 64'h0000_0000_0000_000F);
      check("m3x5_busy_done", {63'd0, bus.Busy}, 64'd0);
      $display("TXN mul 3*5 product=%h cycles=%0d", bus.Product, cyc);
      step();
      check("done_hold_ready", {63'd0, bus.Ready}, 64'd1);
      check("done_hold_product", bus.Product, 64'h0000_0000_0000_000F);

      // carry captured on every iteration
      start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      wait_ready(cyc, busy_cyc, addu_seen);
      check("max_cycles", 64'(cyc), 64'd32);
      check("max_product", bus.Product, 64'hFFFF_FFFE_0000_0001);
      check("max_product_hi", {32'd0, bus.Product_hi}, 64'h0000_0000_FFFF_FFFE);
      check("max_mcand", {32'd0, bus.Multiplicand}, 64'h0000_0000_FFFF_FFFF);
      $display("TXN mul FFFFFFFF*FFFFFFFF product=%h cycles=%0d", bus.Product, cyc);

      // zero multiplier: adder never enabled
      start_op(32'h1234_5678, 32'd0, 1'b0);
      wait_ready(cyc, busy_cyc, addu_seen);
      check("zero_addu_seen", {63'd0, addu_seen}, 64'd0);
      check("zero_product", bus.Product, 64'd0);
      check("zero_ready", {63'd0, bus.Ready}, 64'd1);
      $display("TXN mul 12345678*0 product=%h cycles=%0d", bus.Product, cyc);

      // Run pulses during CALC are ignored
      start_op(32'd7, 32'd9, 1'b0);
      repeat (5) step();
      bus.Run = 1'b1; bus.Multiplicand_in = 32'd11; bus.Multiplier_in = 32'd13;
      step();
      bus.Run = 1'b0;
      repeat (14) step();
      bus.Run = 1'b1; bus.Multiplicand_in = 32'd100; bus.Multiplier_in = 32'd200;
      step();
      bus.Run = 1'b0;
      check("ignore_mcand", {32'd0, bus.Multiplicand}, 64'd7);
      check("ignore_busy", {63'd0, bus.Busy}, 64'd1);
      wait_ready(cyc, busy_cyc, addu_seen);
      check("ignore_remaining_cycles", 64'(cyc), 64'd11);
      check("ignore_product", bus.Product, 64'd63);
      $display("TXN mul 7*9 with ignored Run product=%h", bus.Product);

      // reset mid-CALC
      start_op(32'd6, 32'd7, 1'b0);
      repeat (10) step();
      check("midrst_busy_before", {63'd0, bus.Busy}, 64'd1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("midrst_busy", {63'd0, bus.Busy}, 64'd0);
      check("midrst_ready", {63'd0, bus.Ready}, 64'd0);
      check("midrst_product", bus.Product, 64'd0);
      check("midrst_mcand", {32'd0, bus.Multiplicand}, 64'd0);
      step();
      check("midrst_idle_busy", {63'd0, bus.Busy}, 64'd0);
      start_op(32'd6, 32'd7, 1'b0);
      wait_ready(cyc, busy_cyc, addu_seen);
      check("after_rst_cycles", 64'(cyc), 64'd32);
      check("after_rst_product", bus.Product, 64'd42);
      $display("TXN mul 6*7 after reset product=%h", bus.Product);

      // back-to-back with Run held high through DONE
      start_op(32'd2, 32'd3, 1'b1);
      bus.Multiplicand_in = 32'd4;
      bus.Multiplier_in   = 32'd4;
      wait_ready(cyc, busy_cyc, addu_seen);
      check("b2b_first_cycles", 64'(cyc), 64'd32);
      check("b2b_first_product", bus.Product, 64'd6);
      $display("TXN mul 2*3 product=%h", bus.Product);
      step();
      check("b2b_ready_drop", {63'd0, bus.Ready}, 64'd0);
      check("b2b_busy", {63'd0, bus.Busy}, 64'd1);
      check("b2b_reload_product", bus.Product, 64'd4);
      check("b2b_reload_mcand", {32'd0, bus.Multiplicand}, 64'd4);
      wait_ready(cyc, busy_cyc, addu_seen);
      bus.Run = 1'b0;
      check("b2b_second_cycles", 64'(cyc), 64'd32);
      check("b2b_second_product", bus.Product, 64'd16);
      $display("TXN mul 4*4 back-to-back product=%h", bus.Product);
      step();
      check("b2b_hold_ready", {63'd0, bus.Ready}, 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
